// File: rtl/hash_store_sequencer_pkg.sv
// Shared constants and state encoding for the hash write-back sequencer and its helpers.
package hash_store_sequencer_pkg;

    localparam int unsigned HASH_WORD_WIDTH     = 32;
    localparam int unsigned DEFAULT_HASH_LENGTH = 8;
    localparam int unsigned DEFAULT_ADDR_WIDTH  = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/hash_store_sequencer_if.sv
// Word-wide memory write port: the sequencer drives it as master, the memory answers as slave.
interface hash_store_sequencer_if
    import hash_store_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) ();

    logic                       mem_write;
    logic                       mem_ready;
    logic [ADDR_WIDTH-1:0]      mem_address;
    logic [HASH_WORD_WIDTH-1:0] mem_data;

    modport master (
        output mem_write,
        output mem_address,
        output mem_data,
        input  mem_ready
    );

    modport slave (
        input  mem_write,
        input  mem_address,
        input  mem_data,
        output mem_ready
    );

endinterface

// File: rtl/hash_word_select.sv
// Combinational readout of one 32-bit word from a packed hash vector (word 0 in the low bits).
module hash_word_select
    import hash_store_sequencer_pkg::*;
#(
    parameter int unsigned HASH_LENGTH = DEFAULT_HASH_LENGTH,
    parameter int unsigned INDEX_WIDTH = (HASH_LENGTH > 1) ? $clog2(HASH_LENGTH) : 1
) (
    input  logic [HASH_WORD_WIDTH*HASH_LENGTH-1:0] hash,
    input  logic [INDEX_WIDTH-1:0]                 index,
    output logic [HASH_WORD_WIDTH-1:0]             word
);

    always_comb begin
        word = '0;
        for (int unsigned i = 0; i < HASH_LENGTH; i++) begin
            if (index == INDEX_WIDTH'(i)) begin
                word = hash[HASH_WORD_WIDTH*i +: HASH_WORD_WIDTH];
            end
        end
    end

endmodule

// File: rtl/hash_store_sequencer.sv
// Writes a snapshotted hash to memory one word per accepted write, then pulses done.
// All outputs are registered; abort terminates silently, reset has top priority.
module hash_store_sequencer
    import hash_store_sequencer_pkg::*;
#(
    parameter int unsigned  HASH_LENGTH = DEFAULT_HASH_LENGTH,
    parameter int unsigned  ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    localparam int unsigned INDEX_WIDTH = (HASH_LENGTH > 1) ? $clog2(HASH_LENGTH) : 1
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic                                   abort,
    input  logic [HASH_WORD_WIDTH*HASH_LENGTH-1:0] hash_vector,
    input  logic [ADDR_WIDTH-1:0]                  base_address,
    hash_store_sequencer_if.master                 mem,
    output logic [INDEX_WIDTH-1:0]                 word_index,
    output logic                                   busy,
    output logic                                   done
);

    localparam int unsigned LAST_INDEX = HASH_LENGTH - 1;

    state_e                                 state;
    logic [HASH_WORD_WIDTH*HASH_LENGTH-1:0] snap_hash;
    logic [ADDR_WIDTH-1:0]                  snap_base;
    logic [INDEX_WIDTH-1:0]                 next_index;
    logic [HASH_WORD_WIDTH-1:0]             next_word;
    logic                                   accept;

    assign accept     = mem.mem_write & mem.mem_ready;
    assign next_index = word_index + 1'b1;

    // Pre-fetch the following word so data can advance on the same edge as the accept.
    hash_word_select #(
        .HASH_LENGTH (HASH_LENGTH),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_word_select (
        .hash  (snap_hash),
        .index (next_index),
        .word  (next_word)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= StIdle;
            snap_hash       <= '0;
            snap_base       <= '0;
            word_index      <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            mem.mem_write   <= 1'b0;
            mem.mem_address <= '0;
            mem.mem_data    <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        snap_hash       <= hash_vector;
                        snap_base       <= base_address;
                        word_index      <= '0;
                        mem.mem_address <= base_address;
                        mem.mem_data    <= hash_vector[HASH_WORD_WIDTH-1:0];
                        mem.mem_write   <= 1'b1;
                        busy            <= 1'b1;
                        state           <= StWrite;
                    end
                end
                StWrite: begin
                    // Abort wins even on the final accept: the write lands but no done.
                    if (abort) begin
                        mem.mem_write <= 1'b0;
                        busy          <= 1'b0;
                        word_index    <= '0;
                        state         <= StIdle;
                    end else if (accept) begin
                        if (word_index == INDEX_WIDTH'(LAST_INDEX)) begin
                            mem.mem_write <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            word_index    <= '0;
                            state         <= StDone;
                        end else begin
                            word_index      <= next_index;
                            mem.mem_address <= snap_base + ADDR_WIDTH'(next_index);
                            mem.mem_data    <= next_word;
                        end
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_store_sequencer.sv
// Scoreboard bench: stores push expected writes, a negedge monitor pops and checks them.
module tb_hash_store_sequencer;

    localparam int unsigned HL = 8;
    localparam int unsigned AW = 16;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        int          idx;
    } exp_t;

    logic           clock;
    logic           reset;
    logic           start;
    logic           abort;
    logic [255:0]   hash_vector;
    logic [15:0]    base_address;
    logic [2:0]     word_index;
    logic           busy;
    logic           done;

    hash_store_sequencer_if #(.ADDR_WIDTH(AW)) mem ();

    hash_store_sequencer #(
        .HASH_LENGTH (HL),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .hash_vector  (hash_vector),
        .base_address (base_address),
        .mem          (mem),
        .word_index   (word_index),
        .busy         (busy),
        .done         (done)
    );

    exp_t exp_q[$];
    int   exp_done;
    int   checks;
    int   errors;
    int   cyc;
    int   first_write_cyc;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clock);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [255:0] rand_hash();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Reference: a store of hv at base b is HL writes of word i to (b+i) mod 2^16, then one done.
    task automatic push_expect(input logic [15:0] b, input logic [255:0] hv);
        exp_t e;
        for (int i = 0; i < HL; i++) begin
            e.addr = b + 16'(i);
            e.data = hv[32*i +: 32];
            e.idx  = i;
            exp_q.push_back(e);
        end
        exp_done++;
    endtask

    // Monitor
    initial begin
        bit          stall_prev;
        logic [15:0] addr_prev;
        logic [31:0] data_prev;
        logic [2:0]  idx_prev;
        exp_t        e;
        stall_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                check("busy_tracks_write", 64'(busy), 64'(mem.mem_write));
                if (stall_prev) begin
                    check("hold_write", 64'(mem.mem_write), 64'd1);
                    check("hold_addr", 64'(mem.mem_address), 64'(addr_prev));
                    check("hold_data", 64'(mem.mem_data), 64'(data_prev));
                    check("hold_index", 64'(word_index), 64'(idx_prev));
                end
                if (mem.mem_write && mem.mem_ready) begin
                    check("write_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("write_addr", 64'(mem.mem_address), 64'(e.addr));
                        check("write_data", 64'(mem.mem_data), 64'(e.data));
                        check("write_index", 64'(word_index), 64'(e.idx));
                        if (e.idx == 0) first_write_cyc = cyc;
                    end
                end
                if (done) begin
                    check("done_expected", 64'(exp_done > 0), 64'd1);
                    check("done_no_write", 64'(mem.mem_write), 64'd0);
                    if (exp_done > 0) exp_done--;
                end
                stall_prev = mem.mem_write && !mem.mem_ready && !abort;
                addr_prev  = mem.mem_address;
                data_prev  = mem.mem_data;
                idx_prev   = word_index;
            end
        end
    end

    // mode 0: ready high, 1: stall 3 cycles on word 2, 2: random ready/start, 3: disturb at +3
    task automatic run_store(input logic [15:0] b, input logic [255:0] hv, input int mode,
                             output int t_start, output int t_done);
        int stalls;
        bit seen;
        stalls       = 0;
        seen         = 1'b0;
        t_done       = -1;
        base_address = b;
        hash_vector  = hv;
        start        = 1'b1;
        mem.mem_ready = 1'b1;
        push_expect(b, hv);
        t_start = cyc;
        tick();
        for (int n = 0; n < 300; n++) begin
            if (done) begin
                seen   = 1'b1;
                t_done = cyc;
                break;
            end
            start = 1'b0;
            case (mode)
                1: begin
                    if (mem.mem_write && word_index == 3'd2 && stalls < 3) begin
                        mem.mem_ready = 1'b0;
                        stalls++;
                    end else begin
                        mem.mem_ready = 1'b1;
                    end
                end
                2: begin
                    mem.mem_ready = ($urandom_range(0, 3) != 0);
                    start         = ($urandom_range(0, 7) == 0);
                end
                3: begin
                    mem.mem_ready = 1'b1;
                    if (cyc == t_start + 3) begin
                        hash_vector  = ~hv;
                        base_address = b + 16'h0055;
                        start        = 1'b1;
                    end
                end
                default: mem.mem_ready = 1'b1;
            endcase
            tick();
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL store_timeout: no done, base 0x%0h mode %0d", b, mode);
        end
        // start during the done cycle must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        mem.mem_ready = 1'b1;
        tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("done_consumed", 64'(exp_done), 64'd0);
    endtask

    task automatic flush();
        exp_q.delete();
        exp_done = 0;
    endtask

    task automatic advance_to_index(input logic [2:0] idx, input string name);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (mem.mem_write && word_index == idx) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL %s: word index %0d never presented", name, idx);
        end
    endtask

    initial begin
        int ts;
        int td;
        logic [255:0] hv;
        logic [255:0] sha_init;
        checks = 0;
        errors = 0;
        exp_done = 0;
        first_write_cyc = -1;
        sha_init = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        hash_vector = '0;
        base_address = '0;
        mem.mem_ready = 1'b0;
        repeat (3) tick();
        check("rst_mem_write", 64'(mem.mem_write), 64'd0);
        check("rst_mem_address", 64'(mem.mem_address), 64'd0);
        check("rst_mem_data", 64'(mem.mem_data), 64'd0);
        check("rst_word_index", 64'(word_index), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        tick();

        // Basic timing with ready tied high
        run_store(16'h0100, sha_init, 0, ts, td);
        check("basic_first_write_cycle", 64'(first_write_cyc), 64'(ts + 1));
        check("basic_done_cycle", 64'(td), 64'(ts + HL + 1));

        // Backpressure on word 2
        run_store(16'h0100, sha_init, 1, ts, td);
        check("stall_done_cycle", 64'(td), 64'(ts + HL + 4));

        // Address wrap
        run_store(16'hFFFE, rand_hash(), 0, ts, td);
        check("wrap_done_cycle", 64'(td), 64'(ts + HL + 1));

        // Snapshot isolation and start-while-busy
        run_store(16'h0300, rand_hash(), 3, ts, td);
        check("snap_done_cycle", 64'(td), 64'(ts + HL + 1));

        // Abort on word 4 under backpressure
        hv = rand_hash();
        base_address = 16'h0200;
        hash_vector = hv;
        start = 1'b1;
        mem.mem_ready = 1'b1;
        push_expect(16'h0200, hv);
        tick();
        start = 1'b0;
        advance_to_index(3'd4, "abort_reach");
        mem.mem_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_mem_write", 64'(mem.mem_write), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_word_index", 64'(word_index), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_pending_words", 64'(exp_q.size()), 64'd4);
        flush();
        mem.mem_ready = 1'b1;
        repeat (3) tick();
        run_store(16'h0400, rand_hash(), 0, ts, td);
        check("post_abort_done_cycle", 64'(td), 64'(ts + HL + 1));

        // Reset during word 5
        hv = rand_hash();
        base_address = 16'h0500;
        hash_vector = hv;
        start = 1'b1;
        push_expect(16'h0500, hv);
        tick();
        start = 1'b0;
        advance_to_index(3'd5, "reset_reach");
        reset = 1'b1;
        tick();
        check("midrst_mem_write", 64'(mem.mem_write), 64'd0);
        check("midrst_mem_address", 64'(mem.mem_address), 64'd0);
        check("midrst_mem_data", 64'(mem.mem_data), 64'd0);
        check("midrst_word_index", 64'(word_index), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        reset = 1'b0;
        flush();
        repeat (2) tick();
        run_store(16'h0600, rand_hash(), 0, ts, td);

        // Random traffic
        for (int k = 0; k < 8; k++) begin
            run_store(16'($urandom), rand_hash(), 2, ts, td);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
